// File: rtl/qspi_target.sv
// Quad-SPI target: decodes command/address nibbles, then writes into or reads back a
// small byte array, or streams a fixed ID byte. All logic runs on the serial clock.
module qspi_target #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned DUMMY   = 0,
    parameter logic [7:0]  ID_BYTE = 8'hC5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs_n,
    input  logic [3:0] mosi,
    output logic [3:0] miso,
    output logic       miso_oe,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       cmd_err
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        StIdle, StCmd, StAddr, StDummy, StWrite, StRead, StId, StIgnore
    } state_e;

    state_e        state_q, state_d;
    logic          phase_q, phase_d;    // 0: next nibble is the high one
    logic [3:0]    hi_q, hi_d;
    logic          is_read_q, is_read_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [3:0]    dcnt_q, dcnt_d;

    logic [3:0]    miso_d;
    logic          miso_oe_d;
    logic          wr_valid_d;
    logic [7:0]    wr_addr_d;
    logic [7:0]    wr_data_d;
    logic          cmd_err_d;
    logic          mem_we;

    logic [7:0]    mem [DEPTH];
    logic [7:0]    byte_in;
    logic [7:0]    rd_byte;

    assign byte_in = {hi_q, mosi};
    assign rd_byte = mem[ptr_q];

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        hi_d       = hi_q;
        is_read_d  = is_read_q;
        ptr_d      = ptr_q;
        dcnt_d     = dcnt_q;
        miso_d     = miso;
        miso_oe_d  = miso_oe;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr;
        wr_data_d  = wr_data;
        cmd_err_d  = cmd_err;
        mem_we     = 1'b0;

        if (cs_n) begin
            // Deselect drops any half-assembled byte and the burst pointer.
            state_d   = StIdle;
            phase_d   = 1'b0;
            hi_d      = '0;
            ptr_d     = '0;
            miso_d    = '0;
            miso_oe_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    hi_d    = mosi;
                    phase_d = 1'b1;
                    state_d = StCmd;
                end
                StCmd: begin
                    phase_d = 1'b0;
                    case (byte_in)
                        8'h02: begin
                            is_read_d = 1'b0;
                            state_d   = StAddr;
                        end
                        8'h03: begin
                            is_read_d = 1'b1;
                            state_d   = StAddr;
                        end
                        8'h9F: state_d = StId;
                        default: begin
                            state_d   = StIgnore;
                            cmd_err_d = 1'b1;
                        end
                    endcase
                end
                StAddr: begin
                    if (!phase_q) begin
                        hi_d    = mosi;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        ptr_d   = byte_in[AW-1:0];
                        dcnt_d  = '0;
                        if (!is_read_q) begin
                            state_d = StWrite;
                        end else if (DUMMY > 0) begin
                            state_d = StDummy;
                        end else begin
                            state_d = StRead;
                        end
                    end
                end
                StDummy: begin
                    dcnt_d = dcnt_q + 4'd1;
                    if (dcnt_q == 4'(DUMMY - 1)) begin
                        state_d = StRead;
                    end
                end
                StWrite: begin
                    if (!phase_q) begin
                        hi_d    = mosi;
                        phase_d = 1'b1;
                    end else begin
                        phase_d    = 1'b0;
                        mem_we     = 1'b1;
                        wr_valid_d = 1'b1;
                        wr_addr_d  = 8'(ptr_q);
                        wr_data_d  = byte_in;
                        ptr_d      = ptr_q + 1'b1;
                    end
                end
                StRead: begin
                    miso_oe_d = 1'b1;
                    if (!phase_q) begin
                        miso_d  = rd_byte[7:4];
                        phase_d = 1'b1;
                    end else begin
                        miso_d  = rd_byte[3:0];
                        phase_d = 1'b0;
                        ptr_d   = ptr_q + 1'b1;
                    end
                end
                StId: begin
                    miso_oe_d = 1'b1;
                    miso_d    = phase_q ? ID_BYTE[3:0] : ID_BYTE[7:4];
                    phase_d   = ~phase_q;
                end
                StIgnore: begin
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            phase_q   <= 1'b0;
            hi_q      <= '0;
            is_read_q <= 1'b0;
            ptr_q     <= '0;
            dcnt_q    <= '0;
            miso      <= '0;
            miso_oe   <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            cmd_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            hi_q      <= hi_d;
            is_read_q <= is_read_d;
            ptr_q     <= ptr_d;
            dcnt_q    <= dcnt_d;
            miso      <= miso_d;
            miso_oe   <= miso_oe_d;
            wr_valid  <= wr_valid_d;
            wr_addr   <= wr_addr_d;
            wr_data   <= wr_data_d;
            cmd_err   <= cmd_err_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            mem[ptr_q] <= byte_in;
        end
    end

endmodule

// File: tb/tb_qspi_target.sv
// Bench for qspi_target: two instances (DUMMY=0 and DUMMY=2) share one stimulus stream and
// are checked against a byte-array model of the storage.
module tb_qspi_target;
    logic       clk = 1'b0;
    logic       reset;
    logic       cs_n;
    logic [3:0] mosi;

    logic [3:0] miso_a, miso_b;
    logic       oe_a, oe_b, wv_a, wv_b, err_a, err_b;
    logic [7:0] wa_a, wa_b, wd_a, wd_b;

    logic [7:0]  model [16];
    logic        err_exp;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    qspi_target #(.DEPTH(16), .DUMMY(0), .ID_BYTE(8'hC5)) dut_a (
        .clk(clk), .reset(reset), .cs_n(cs_n), .mosi(mosi), .miso(miso_a), .miso_oe(oe_a),
        .wr_valid(wv_a), .wr_addr(wa_a), .wr_data(wd_a), .cmd_err(err_a)
    );

    qspi_target #(.DEPTH(16), .DUMMY(2), .ID_BYTE(8'hC5)) dut_b (
        .clk(clk), .reset(reset), .cs_n(cs_n), .mosi(mosi), .miso(miso_b), .miso_oe(oe_b),
        .wr_valid(wv_b), .wr_addr(wa_b), .wr_data(wd_b), .cmd_err(err_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are looked at 1ns after the rising edge.
    task automatic edge_drive(input logic cs, input logic [3:0] nib);
        @(negedge clk);
        cs_n = cs;
        mosi = nib;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        edge_drive(1'b0, b[7:4]);
        edge_drive(1'b0, b[3:0]);
    endtask

    task automatic deselect();
        edge_drive(1'b1, 4'($urandom));
        check_eq("desel_oe_a", 32'(oe_a), 0);
        check_eq("desel_oe_b", 32'(oe_b), 0);
        check_eq("desel_miso_a", 32'(miso_a), 0);
        check_eq("desel_miso_b", 32'(miso_b), 0);
        check_eq("desel_wv_a", 32'(wv_a), 0);
        check_eq("desel_wv_b", 32'(wv_b), 0);
    endtask

    function automatic logic [3:0] nib_of(input logic [7:0] addr, input int j);
        logic [7:0] bv;
        bv = model[(int'(addr) + j / 2) % 16];
        return (j % 2 == 1) ? bv[3:0] : bv[7:4];
    endfunction

    task automatic write_txn(input logic [7:0] addr, input int n, input logic [31:0] payload);
        logic [7:0] b;
        int         a;
        send_byte(8'h02);
        send_byte(addr);
        for (int i = 0; i < n; i++) begin
            b = payload[31 - 8 * i -: 8];
            a = (int'(addr) + i) % 16;
            edge_drive(1'b0, b[7:4]);
            check_eq("wr_gap_a", 32'(wv_a), 0);
            check_eq("wr_gap_b", 32'(wv_b), 0);
            edge_drive(1'b0, b[3:0]);
            check_eq("wr_valid_a", 32'(wv_a), 1);
            check_eq("wr_valid_b", 32'(wv_b), 1);
            check_eq("wr_addr_a", 32'(wa_a), 32'(a));
            check_eq("wr_addr_b", 32'(wa_b), 32'(a));
            check_eq("wr_data_a", 32'(wd_a), 32'(b));
            check_eq("wr_data_b", 32'(wd_b), 32'(b));
            check_eq("wr_oe_a", 32'(oe_a), 0);
            model[a] = b;
        end
        deselect();
    endtask

    // dut_a streams from E5, dut_b stays off the bus for two dummy edges first.
    task automatic read_txn(input logic [7:0] addr, input int n);
        send_byte(8'h03);
        send_byte(addr);
        for (int j = 0; j < 2 * n + 2; j++) begin
            edge_drive(1'b0, 4'($urandom));
            check_eq("rd_miso_a", 32'(miso_a), 32'(nib_of(addr, j)));
            check_eq("rd_oe_a", 32'(oe_a), 1);
            if (j < 2) begin
                check_eq("rd_dummy_oe_b", 32'(oe_b), 0);
            end else begin
                check_eq("rd_miso_b", 32'(miso_b), 32'(nib_of(addr, j - 2)));
                check_eq("rd_oe_b", 32'(oe_b), 1);
            end
        end
        check_eq("rd_err_a", 32'(err_a), 32'(err_exp));
        check_eq("rd_err_b", 32'(err_b), 32'(err_exp));
        deselect();
    endtask

    task automatic id_txn();
        logic [3:0] exp;
        send_byte(8'h9F);
        for (int j = 0; j < 4; j++) begin
            edge_drive(1'b0, 4'($urandom));
            exp = (j % 2 == 1) ? 4'h5 : 4'hC;
            check_eq("id_miso_a", 32'(miso_a), 32'(exp));
            check_eq("id_miso_b", 32'(miso_b), 32'(exp));
            check_eq("id_oe_a", 32'(oe_a), 1);
            check_eq("id_oe_b", 32'(oe_b), 1);
        end
        deselect();
    endtask

    task automatic bad_txn(input logic [7:0] cmd);
        send_byte(cmd);
        err_exp = 1'b1;
        check_eq("bad_err_a", 32'(err_a), 1);
        check_eq("bad_err_b", 32'(err_b), 1);
        for (int j = 0; j < 4; j++) begin
            edge_drive(1'b0, 4'($urandom));
            check_eq("bad_oe_a", 32'(oe_a), 0);
            check_eq("bad_wv_a", 32'(wv_a), 0);
            check_eq("bad_wv_b", 32'(wv_b), 0);
        end
        deselect();
    endtask

    task automatic abort_txn(input logic [7:0] addr);
        send_byte(8'h02);
        send_byte(addr);
        edge_drive(1'b0, 4'($urandom));
        check_eq("abort_wv_a", 32'(wv_a), 0);
        deselect();
    endtask

    task automatic random_bad();
        logic [7:0] c;
        c = 8'($urandom);
        while (c == 8'h02 || c == 8'h03 || c == 8'h9F) c = 8'($urandom);
        bad_txn(c);
    endtask

    initial begin
        int kind;
        reset = 1'b1;
        cs_n  = 1'b1;
        mosi  = 4'h0;
        err_exp = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_miso", 32'(miso_a), 0);
        check_eq("rst_oe", 32'(oe_a), 0);
        check_eq("rst_wv", 32'(wv_a), 0);
        check_eq("rst_wa", 32'(wa_a), 0);
        check_eq("rst_wd", 32'(wd_a), 0);
        check_eq("rst_err", 32'(err_a), 0);
        @(negedge clk);
        reset = 1'b0;

        write_txn(8'h03, 1, 32'hA500_0000);
        read_txn(8'h03, 1);
        write_txn(8'h0F, 2, 32'h1122_0000);
        read_txn(8'h0F, 2);
        write_txn(8'h00, 1, 32'h3C00_0000);
        read_txn(8'h00, 1);
        id_txn();
        read_txn(8'h04, 1);
        abort_txn(8'h04);
        read_txn(8'h04, 1);
        bad_txn(8'h55);
        read_txn(8'h03, 1);

        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 4) write_txn(8'($urandom), int'($urandom_range(1, 4)), $urandom);
            else if (kind < 8) read_txn(8'($urandom), int'($urandom_range(1, 3)));
            else if (kind == 8) id_txn();
            else if (it % 2 == 0) abort_txn(8'($urandom));
            else random_bad();
        end

        // Reset in the middle of a read burst.
        send_byte(8'h03);
        send_byte(8'h03);
        repeat (3) edge_drive(1'b0, 4'($urandom));
        #2;
        reset = 1'b1;
        #1;
        check_eq("rstmid_oe_a", 32'(oe_a), 0);
        check_eq("rstmid_oe_b", 32'(oe_b), 0);
        check_eq("rstmid_err_a", 32'(err_a), 0);
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        err_exp = 1'b0;
        @(negedge clk);
        cs_n = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        read_txn(8'h03, 1);
        read_txn(8'h0F, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/qspi_target.md
# qspi_target

Quad-SPI target (responder) that terminates the 4-line serial link driven by the team's quad-SPI master, standing in for the external flash device. Decodes a command byte and an address byte from the MOSI nibbles, then either writes incoming bytes into an internal byte-wide register array or returns array contents (or a fixed ID byte) on the MISO nibbles. Used as the bench/FPGA loopback target and as the model of the flash-side behaviour.

## Interface
- DEPTH, 16: bytes of storage; power of two, 2..256; address byte is taken modulo DEPTH
- DUMMY, 0: turnaround cycles between address and first read nibble (0..15)
- ID_BYTE, 8'hC5: value returned by the ID command

- clk  in  1  serial clock (the master's sclk); all logic on rising edge
- reset  in  1  asynchronous, active-high
- cs_n  in  1  chip select, active low, sampled on rising clk
- mosi  in  4  nibble from master; mosi[3] = bit 7/3 of byte, mosi[0] = bit 4/0
- miso  out  4  nibble to master, same bit mapping
- miso_oe  out  1  high while target drives miso
- wr_valid  out  1  one-cycle pulse per byte committed to the array
- wr_addr  out  8  address of committed byte (zero-extended)
- wr_data  out  8  committed byte
- cmd_err  out  1  sticky; set on unknown command, cleared by reset only

## Operation
- Bytes are MSB-nibble first: high nibble on first edge, low nibble on second.
- States: IDLE, CMD, ADDR, DUMMY, WRITE, READ, ID, IGNORE; a nibble-phase flag (HI/LO) tracks byte position.
- IDLE: cs_n=0 at an edge captures command high nibble, go CMD (phase LO).
- CMD LO edge completes command: 8'h02 -> ADDR (write), 8'h03 -> ADDR (read), 8'h9F -> ID, other -> IGNORE and set cmd_err.
- ADDR: two edges; address pointer = byte mod DEPTH. Write -> WRITE; read -> DUMMY if DUMMY>0, else READ.
- DUMMY: counts DUMMY edges, miso_oe=0, then READ.
- WRITE: each nibble pair forms a byte; on LO edge mem[ptr] <= byte, wr_valid/wr_addr/wr_data registered on same edge, ptr <= (ptr+1) mod DEPTH.
- READ: first edge drives mem[ptr][7:4], next mem[ptr][3:0], then ptr increments (wraps DEPTH-1 -> 0) and repeats; miso_oe=1 throughout.
- ID: drives ID_BYTE[7:4], ID_BYTE[3:0], repeating until deselect.
- IGNORE: no outputs change until deselect.
- cs_n=1 at any edge: state IDLE, phase HI, miso_oe=0, miso=0, any half-assembled byte discarded (not written), pointer not retained.
- Reads of a location written earlier in the same burst return the new value.

## Timing
- Reset values: miso=0, miso_oe=0, wr_valid=0, wr_addr=0, wr_data=0, cmd_err=0, state IDLE, all array bytes 0.
- Reset mid-transfer: immediate return to reset values; array cleared.
- Edge numbering from first edge with cs_n=0 as E1: E1-E2 command, E3-E4 address, E5+ write data or dummy.
- Read: first data nibble driven at edge E5+DUMMY, valid for the following falling edge (master samples on falling edge); one new nibble per edge thereafter.
- ID: first nibble at E3.
- Write: byte n committed at edge E6+2n; wr_valid high for exactly that cycle.
- cs_n and mosi must be stable around rising clk; no synchronizers (clk is the serial clock).

## Test plan
- Reset, then write cmd 02, addr 03, data A5 -> wr_valid at E6 with wr_addr=03, wr_data=A5; read cmd 03 addr 03 -> miso A then 5 at E5/E6, miso_oe=1.
- DEPTH=16 burst write at addr 0F of bytes 11,22 -> commits to 0F then 00; read at 0F returns 1,1,2,2.
- DUMMY=2, read addr 00 after writing 3C -> miso_oe low E5-E6, nibbles 3 at E7, C at E8.
- Cmd 9F -> miso C,5,C,5 from E3; cmd 55 -> cmd_err=1, miso_oe stays 0, no wr_valid.
- Write cmd, addr 04, one nibble then cs_n=1 -> no wr_valid, mem[04] unchanged; next transaction decodes normally.
- Assert reset during read burst -> miso_oe=0 immediately, subsequent read of written address returns 00.
